// File: rtl/stack_ctrl_if.sv
// Request/response channel between a requester (master) and the stack controller (slave).
// Handshake: a beat moves on a rising edge where valid and ready are both 1; the
// sender holds its payload stable while valid=1 and ready=0; valid never waits on ready.
interface stack_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       resp_err;

  modport master (
    output req_valid, req_op, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Byte stack controller: PUSH/POP/PEEK/CLEAR against an external single-port RAM
// with one-cycle read latency, sticky overflow/underflow flags and a debug state view.
module stack_ctrl #(
  parameter int DEPTH = 255
) (
  input  logic        clk,
  input  logic        reset,
  stack_ctrl_if.slave bus,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  sp,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic        unf,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [7:0] DEPTH_B  = 8'(DEPTH);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] sp_q, sp_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic       resp_err_q, resp_err_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       full_w, empty_w;
  logic       req_ready_w, resp_valid_w;

  assign full_w  = (sp_q == DEPTH_B);
  assign empty_w = (sp_q == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      data_q      <= 8'h00;
      sp_q        <= 8'h00;
      resp_data_q <= 8'h00;
      resp_err_q  <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      sp_q        <= sp_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    sp_d         = sp_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    req_ready_w  = 1'b0;
    resp_valid_w = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = 8'h00;
    mem_wdata    = 8'h00;

    case (state_q)
      IDLE: begin
        // Gating on reset keeps ready low while the async reset is held.
        req_ready_w = reset;
        if (bus.req_valid && req_ready_w) begin
          op_d        = bus.req_op;
          data_d      = bus.req_data;
          resp_err_d  = 1'b0;
          resp_data_d = 8'h00;
          case (bus.req_op)
            OP_PUSH: begin
              if (full_w) begin
                resp_err_d = 1'b1;
                ovf_d      = 1'b1;
                state_d    = RESP;
              end else begin
                resp_data_d = bus.req_data;
                state_d     = WRITE;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty_w) begin
                resp_err_d = 1'b1;
                unf_d      = 1'b1;
                state_d    = RESP;
              end else begin
                state_d = READ;
              end
            end
            default: begin
              sp_d    = 8'h00;
              ovf_d   = 1'b0;
              unf_d   = 1'b0;
              state_d = RESP;
            end
          endcase
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = data_q;
        sp_d      = sp_q + 8'd1;
        state_d   = RESP;
      end
      READ: begin
        mem_re   = 1'b1;
        mem_addr = sp_q - 8'd1;
        if (op_q == OP_POP) begin
          sp_d = sp_q - 8'd1;
        end
        state_d = CAPT;
      end
      CAPT: begin
        resp_data_d = mem_rdata;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_w = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_w;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign sp             = sp_q;
  assign full           = full_w;
  assign empty          = empty_w;
  assign ovf            = ovf_q;
  assign unf            = unf_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios with literal expectations plus randomized
// operations scored against a queue-based stack model.
module tb_stack_ctrl;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if bus ();
  logic [7:0] mem_addr, mem_wdata, mem_rdata, sp;
  logic       mem_we, mem_re, full, empty, ovf, unf;
  logic [2:0] dbg_state;

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf),
    .dbg_state (dbg_state)
  );

  // Stack RAM with registered read data.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  logic [7:0] model_q[$];
  bit         m_ovf, m_unf;
  int         we_log[$];
  int         re_log[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) we_log.push_back({16'h0, mem_addr, mem_wdata});
      if (mem_re) re_log.push_back({24'h0, mem_addr});
      if (mem_we && mem_re) check("we_re_overlap", 1, 0);
      if (bus.req_ready) begin
        check("idle_sp", sp, model_q.size());
        check("idle_full", full, model_q.size() == DEPTH);
        check("idle_empty", empty, model_q.size() == 0);
        check("idle_ovf", ovf, m_ovf);
        check("idle_unf", unf, m_unf);
        check("idle_strobes", {mem_we, mem_re, bus.resp_valid}, 0);
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_err_data", {bus.resp_err, bus.resp_data}, exp_q[0]);
      end
    end
  end

  always @(posedge clk) begin
    if (reset && bus.resp_valid && bus.resp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // ---------------- driver ----------------
  task automatic do_op(input logic [1:0] op, input logic [7:0] data, input int hold,
                       output logic [7:0] got_data, output logic got_err, output int got_lat);
    int wait_n, lat, exp_lat, exp_we, exp_re, sz;
    logic [8:0] exp_r;
    got_data = 8'h00; got_err = 1'b0; got_lat = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = op;
    bus.req_data   = data;
    bus.resp_ready = (hold == 0);
    wait_n = 0;
    while (!bus.req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    sz = model_q.size();
    exp_we = -1; exp_re = -1;
    case (op)
      2'b00: if (sz == DEPTH) begin exp_r = 9'h100; exp_lat = 1; end
             else begin exp_r = {1'b0, data}; exp_lat = 2; exp_we = {sz[7:0], data}; end
      2'b01, 2'b10: if (sz == 0) begin exp_r = 9'h100; exp_lat = 1; end
             else begin exp_r = {1'b0, model_q[sz-1]}; exp_lat = 3; exp_re = sz - 1; end
      default: begin exp_r = 9'h000; exp_lat = 1; end
    endcase
    exp_q.push_back(exp_r);
    we_log.delete();
    re_log.delete();
    @(negedge clk);
    bus.req_valid = 1'b0;
    case (op)
      2'b00: if (sz == DEPTH) m_ovf = 1'b1; else model_q.push_back(data);
      2'b01: if (sz == 0) m_unf = 1'b1; else void'(model_q.pop_back());
      2'b10: if (sz == 0) m_unf = 1'b1;
      default: begin model_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; end
    endcase
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    got_data = bus.resp_data; got_err = bus.resp_err; got_lat = lat;
    for (int i = 0; i < hold; i++) begin
      check("hold_req_ready", bus.req_ready, 0);
      check("hold_sp", sp, model_q.size());
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op    = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("we_count", we_log.size(), exp_we >= 0);
    if (exp_we >= 0 && we_log.size() > 0) check("we_addr_data", we_log[0], exp_we);
    check("re_count", re_log.size(), exp_re >= 0);
    if (exp_re >= 0 && re_log.size() > 0) check("re_addr", re_log[0], exp_re);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_ready_valid"}, {bus.req_ready, bus.resp_valid, bus.resp_err}, 0);
    check({tag, "_rst_resp_data"}, bus.resp_data, 0);
    check({tag, "_rst_mem"}, {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    check({tag, "_rst_sp"}, sp, 0);
    check({tag, "_rst_flags"}, {full, empty, ovf, unf}, 4'b0100);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] d;
  logic       e;
  int         l;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 8'h00; bus.resp_ready = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0;
    #2;
    check_reset_outputs("init");
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("ready_after_release", bus.req_ready, 1);

    // Single push.
    do_op(2'b00, 8'hA5, 0, d, e, l);
    check("push_a5_lat", l, 2);
    check("push_a5_data", {e, d}, {1'b0, 8'hA5});
    check("push_a5_we", we_log.size() > 0 ? we_log[0] : -1, 16'h00A5);
    check("push_a5_sp", {sp, empty}, {8'h01, 1'b0});

    // LIFO order from an empty stack.
    do_op(2'b11, 8'h00, 0, d, e, l);
    check("clear_lat_sp", {l[3:0], sp}, {4'd1, 8'h00});
    do_op(2'b00, 8'h11, 0, d, e, l);
    do_op(2'b00, 8'h22, 0, d, e, l);
    do_op(2'b01, 8'h00, 0, d, e, l);
    check("pop1", {l[3:0], e, d, re_log.size() > 0 ? re_log[0][7:0] : 8'hFF}, {4'd3, 1'b0, 8'h22, 8'h01});
    do_op(2'b01, 8'h00, 0, d, e, l);
    check("pop2", {e, d, re_log.size() > 0 ? re_log[0][7:0] : 8'hFF}, {1'b0, 8'h11, 8'h00});
    check("pop2_sp", {sp, empty}, {8'h00, 1'b1});

    // Underflow then clear.
    do_op(2'b01, 8'h00, 0, d, e, l);
    check("unf_resp", {l[3:0], e, d, unf}, {4'd1, 1'b1, 8'h00, 1'b1});
    check("unf_no_re", re_log.size(), 0);
    do_op(2'b11, 8'h00, 0, d, e, l);
    check("unf_cleared", unf, 0);

    // Fill to DEPTH and overflow.
    for (int i = 0; i < 4; i++) do_op(2'b00, 8'(8'h40 + i), 0, d, e, l);
    check("full_after_4", {full, sp}, {1'b1, 8'h04});
    do_op(2'b00, 8'h99, 0, d, e, l);
    check("ovf_resp", {e, d, ovf, sp}, {1'b1, 8'h00, 1'b1, 8'h04});
    do_op(2'b01, 8'h00, 0, d, e, l);
    check("ovf_sticky", {e, d, ovf}, {1'b0, 8'h43, 1'b1});

    // Peek with back-pressure.
    do_op(2'b11, 8'h00, 0, d, e, l);
    do_op(2'b00, 8'h3C, 0, d, e, l);
    do_op(2'b10, 8'h00, 5, d, e, l);
    check("peek_held", {e, d, sp}, {1'b0, 8'h3C, 8'h01});

    // Reset during the READ cycle of a POP.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("pre_abort_re", mem_re, 1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("abort");
    model_q.delete(); exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("abort_hold");
    #1 reset = 1'b1;
    #1 check("abort_ready", bus.req_ready, 1);
    do_op(2'b00, 8'h5E, 0, d, e, l);
    check("abort_push_addr0", we_log.size() > 0 ? we_log[0] : -1, 16'h005E);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_op(op, 8'($urandom_range(0, 255)), $urandom_range(0, 3), d, e, l);
    end

    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
